// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state encoding and frame geometry for the SPI memory target.
// Optional feature macro used by this block: SPI_MEM_SLV_RANGE_CHK_EN.
package spi_mem_pkg;

  localparam int OP_BITS = 1;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OP,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_TX_DATA
  } state_t;

endpackage

// File: rtl/spi_mem_if.sv
// spi_mem_if: serial link between the SPI memory master and this target.
// With SPI_MEM_SLV_RANGE_CHK_EN defined the target also reports addr_err.
interface spi_mem_if;

  logic cs;
  logic mosi;
  logic miso;
  logic ready;
  logic op_done;
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
  logic addr_err;

  modport master (output cs, output mosi, input miso, input ready, input op_done, input addr_err);
  modport slave  (input cs, input mosi, output miso, output ready, output op_done, output addr_err);
`else
  modport master (output cs, output mosi, input miso, input ready, input op_done);
  modport slave  (input cs, input mosi, output miso, output ready, output op_done);
`endif

endinterface

// File: rtl/spi_mem_array.sv
// spi_mem_array: DEPTH x DATA_W register storage, single access port.
// Synchronous write, registered read, every word cleared by the synchronous reset.
module spi_mem_array
  import spi_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wrEn,
  input  logic              i_rdEn,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wrData,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  // Storage update and registered read; the read register holds its value until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdData <= '0;
    end else begin
      if (i_wrEn) begin
        r_mem[i_addr] <= i_wrData;
      end
      if (i_rdEn) begin
        r_rdData <= r_mem[i_addr];
      end
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: deserialises LSB-first op/addr/data frames and serves a register memory.
// Define SPI_MEM_SLV_RANGE_CHK_EN to reject addresses >= DEPTH and pulse addr_err;
// otherwise the address is truncated to $clog2(DEPTH) bits (aliasing).
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input logic      clk,
  input logic      rst,
  spi_mem_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = $clog2(DATA_W);

  state_t             r_state;
  logic [3:0]         r_bitCnt;
  logic [OP_BITS-1:0] r_op;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_miso;
  logic               r_ready;
  logic               r_opDone;

  logic [AW-1:0]      w_memAddr;
  logic               w_wrEn;
  logic               w_rdEn;
  logic [DATA_W-1:0]  w_rdData;

  assign w_memAddr = r_addr[AW-1:0];
  assign w_rdEn    = (r_state == ST_MEM_RD);

`ifdef SPI_MEM_SLV_RANGE_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic w_inRange;
  logic r_addrErr;
  logic r_txMask;

  assign w_inRange    = ({1'b0, r_addr} < DEPTH_LIM);
  assign w_wrEn       = (r_state == ST_MEM_WR) && w_inRange;
  assign bus.addr_err = r_addrErr;
`else
  assign w_wrEn = (r_state == ST_MEM_WR);
`endif

  // The array's read register doubles as the transmit shift source, loaded in MEM_RD.
  spi_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_wrEn),
    .i_rdEn   (w_rdEn),
    .i_addr   (w_memAddr),
    .i_wrData (r_data),
    .o_rdData (w_rdData)
  );

  // Frame FSM: shift in op/addr/data, commit or fetch, then shift read data out with registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_miso   <= 1'b0;
      r_ready  <= 1'b0;
      r_opDone <= 1'b0;
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
      r_addrErr <= 1'b0;
      r_txMask  <= 1'b0;
`endif
    end else begin
      r_ready  <= 1'b0;
      r_opDone <= 1'b0;
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
      r_addrErr <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_bitCnt <= '0;
          r_miso   <= 1'b0;
          if (!bus.cs) begin
            r_state <= ST_RX_OP;
          end
        end
        ST_RX_OP: begin
          if (bus.cs) begin
            r_state <= ST_IDLE;
          end else begin
            r_op     <= bus.mosi;
            r_bitCnt <= '0;
            r_state  <= ST_RX_ADDR;
          end
        end
        ST_RX_ADDR: begin
          if (bus.cs) begin
            r_state <= ST_IDLE;
          end else begin
            r_addr <= {bus.mosi, r_addr[ADDR_W-1:1]};
            if (r_bitCnt == 4'(ADDR_W - 1)) begin
              r_bitCnt <= '0;
              r_state  <= r_op[0] ? ST_RX_DATA : ST_MEM_RD;
            end else begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end
        end
        ST_RX_DATA: begin
          if (bus.cs) begin
            r_state <= ST_IDLE;
          end else begin
            r_data <= {bus.mosi, r_data[DATA_W-1:1]};
            if (r_bitCnt == 4'(DATA_W - 1)) begin
              r_bitCnt <= '0;
              r_state  <= ST_MEM_WR;
            end else begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end
        end
        ST_MEM_WR: begin
          r_opDone <= 1'b1;
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
          r_addrErr <= ~w_inRange;
`endif
          r_state <= ST_IDLE;
        end
        ST_MEM_RD: begin
          r_ready  <= 1'b1;
          r_bitCnt <= '0;
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
          r_addrErr <= ~w_inRange;
          r_txMask  <= w_inRange;
`endif
          r_state <= ST_TX_DATA;
        end
        ST_TX_DATA: begin
          if (r_bitCnt == 4'(DATA_W)) begin
            r_miso  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
            r_miso <= w_rdData[r_bitCnt[IDX_W-1:0]] & r_txMask;
`else
            r_miso <= w_rdData[r_bitCnt[IDX_W-1:0]];
`endif
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.miso    = r_miso;
  assign bus.ready   = r_ready;
  assign bus.op_done = r_opDone;

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb_spi_mem_slave: scenario tasks for spi_mem_slave with a byte-level memory model
// and a queue of expected read bytes. Honours SPI_MEM_SLV_RANGE_CHK_EN when defined.
module tb_spi_mem_slave;

  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  int testsRun;
  int testsFailed;

  logic [7:0] model [DEPTH];
  logic [7:0] expQ [$];

  spi_mem_if bus ();

  spi_mem_slave #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, posedge on 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit addrOk(input logic [7:0] addr);
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
    return (int'(addr) < DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  // Called just after a negedge; returns at the negedge after the commit edge.
  task automatic writeFrame(input logic [7:0] addr, input logic [7:0] data, input string name);
    bus.cs = 1'b0;
    @(negedge clk); bus.mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); bus.mosi = addr[i]; end
    for (int i = 0; i < 8; i++) begin @(negedge clk); bus.mosi = data[i]; end
    @(negedge clk); bus.cs = 1'b1; bus.mosi = 1'b0;
    testsRun++;
    if (bus.op_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s op_done early: got %b want 0", name, bus.op_done);
    end
    @(negedge clk);
    testsRun++;
    if (bus.op_done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s op_done pulse: got %b want 1", name, bus.op_done);
    end
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
    testsRun++;
    if (bus.addr_err !== !addrOk(addr)) begin
      testsFailed++;
      $display("[TB] FAIL %s addr_err on write: got %b want %b", name, bus.addr_err, !addrOk(addr));
    end
`endif
    if (addrOk(addr)) model[addr[4:0]] = data;
  endtask

  // Called just after a negedge; returns at the negedge after miso has been cleared.
  task automatic readFrame(input logic [7:0] addr, input string name);
    int lat;
    int extraReady;
    logic [7:0] got;
    logic [7:0] exp;
    lat = 0;
    extraReady = 0;
    got = 8'h00;
    bus.cs = 1'b0;
    @(negedge clk); bus.mosi = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); bus.mosi = addr[i]; end
    @(negedge clk); bus.cs = 1'b1; bus.mosi = 1'b0;
    expQ.push_back(addrOk(addr) ? model[addr[4:0]] : 8'h00);
    for (int w = 1; w <= 20; w++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin lat = w; break; end
    end
    exp = expQ.pop_front();
    testsRun++;
    if (lat != 1) begin
      testsFailed++;
      $display("[TB] FAIL %s ready latency: got %0d want 1 (0 = timeout)", name, lat);
      return;
    end
    testsRun++;
    if (bus.op_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s op_done during read: got %b want 0", name, bus.op_done);
    end
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
    testsRun++;
    if (bus.addr_err !== !addrOk(addr)) begin
      testsFailed++;
      $display("[TB] FAIL %s addr_err on read: got %b want %b", name, bus.addr_err, !addrOk(addr));
    end
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      got[k] = bus.miso;
      if (bus.ready !== 1'b0) extraReady++;
    end
    testsRun++;
    if (extraReady != 0) begin
      testsFailed++;
      $display("[TB] FAIL %s ready width: got %0d extra cycles want 0", name, extraReady);
    end
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s read data: got %h want %h", name, got, exp);
    end
    @(negedge clk);
    testsRun++;
    if (bus.miso !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s miso idle: got %b want 0", name, bus.miso);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.cs = 1'b1; bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({bus.miso, bus.ready, bus.op_done} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: got %b want 000", {bus.miso, bus.ready, bus.op_done});
    end
`ifdef SPI_MEM_SLV_RANGE_CHK_EN
    testsRun++;
    if (bus.addr_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset addr_err: got %b want 0", bus.addr_err);
    end
`endif
    rst = 1'b0;
    clearModel();
    @(negedge clk);
  endtask

  task automatic test_read_after_reset();
    readFrame(8'd7, "read7_after_reset");
  endtask

  task automatic test_write_read();
    writeFrame(8'd3, 8'hA5, "write3");
    @(negedge clk);
    testsRun++;
    if (bus.op_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL write3 op_done clear: got %b want 0", bus.op_done);
    end
    readFrame(8'd3, "read3");
  endtask

  task automatic test_edges();
    writeFrame(8'd31, 8'h3C, "write31");
    @(negedge clk);
    writeFrame(8'd0, 8'hFF, "write0");
    @(negedge clk);
    readFrame(8'd31, "read31");
    readFrame(8'd0, "read0");
  endtask

  task automatic test_abort();
    int pulses;
    logic [7:0] addr;
    pulses = 0;
    addr = 8'd5;
    bus.cs = 1'b0;
    @(negedge clk); bus.mosi = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); bus.mosi = addr[i]; end
    @(negedge clk); bus.cs = 1'b1; bus.mosi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.op_done !== 1'b0 || bus.ready !== 1'b0) pulses++;
    end
    testsRun++;
    if (pulses != 0) begin
      testsFailed++;
      $display("[TB] FAIL abort pulses: got %0d want 0", pulses);
    end
    readFrame(8'd5, "read5_after_abort");
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    logic [7:0] addr;
    logic [7:0] data;
    pulses = 0;
    addr = 8'd9;
    data = 8'hEE;
    bus.cs = 1'b0;
    @(negedge clk); bus.mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); bus.mosi = addr[i]; end
    for (int i = 0; i < 4; i++) begin @(negedge clk); bus.mosi = data[i]; end
    @(negedge clk); rst = 1'b1; bus.cs = 1'b1; bus.mosi = 1'b0;
    @(negedge clk); rst = 1'b0;
    clearModel();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.op_done !== 1'b0 || bus.ready !== 1'b0 || bus.miso !== 1'b0) pulses++;
    end
    testsRun++;
    if (pulses != 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset activity: got %0d cycles want 0", pulses);
    end
    readFrame(8'd9, "read9_after_reset");
    writeFrame(8'd9, 8'h12, "write9");
    @(negedge clk);
    readFrame(8'd9, "read9");
  endtask

  task automatic test_back_to_back();
    writeFrame(8'd12, 8'hC3, "b2b_write12");
    readFrame(8'd12, "b2b_read12");
    writeFrame(8'd13, 8'h5A, "b2b_write13");
    readFrame(8'd13, "b2b_read13");
    readFrame(8'd3, "b2b_read3");
  endtask

  task automatic test_out_of_range();
    writeFrame(8'd8, 8'h77, "write8");
    writeFrame(8'd40, 8'h55, "write40");
    @(negedge clk);
    readFrame(8'd8, "read8");
    readFrame(8'd40, "read40");
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    clearModel();
    @(negedge clk);
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_edges();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_out_of_range();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d entries want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
